regfile_dump_reader: RTL and testbench

- Debug/trace reader on the register file's read side; walks a contiguous (wrapping) register range and streams each register's contents out.
- Drives a read-address port into the register file.
- Samples the combinational read-data return.
- Emits {addr, data} beats on a valid/ready stream towards the debug/trace logic.
- Shares the register file's read port with the datapath only when the datapath is stalled; arbitration is outside this block.

---
 rtl/mips_dbg_pkg.sv | 18 +
 rtl/regfile_dump_reader.sv | 108 ++++++++++
 tb/tb_regfile_dump_reader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared debug-side definitions: register file geometry and the dump reader's
// state encoding.
package mips_dbg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    SEND  = S_SEND
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping register range on the register file read port and streams
// {addr, data} beats to debug/trace logic over valid/ready.
module regfile_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic [ADDR_W-1:0] cur_inc_d;

  // Index arithmetic is modulo 2^ADDR_W, so the top register wraps to 0.
  assign cur_inc_d = cur_q + ADDR_W'(1);

  // NOTE: every register here is updated with <= so all state advances from
  // the same pre-edge snapshot; blocking writes would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      rd_addr_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cur_q     <= first_addr;
            last_q    <= last_addr;
            rd_addr_q <= first_addr;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= IDLE;
          end else begin
            // rd_addr has been stable for the whole cycle; capture the live value.
            out_data_q  <= rd_data;
            out_addr_q  <= cur_q;
            out_last_q  <= (cur_q == last_q);
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= IDLE;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cur_q     <= cur_inc_d;
              rd_addr_q <= cur_inc_d;
              state_q   <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a behavioural register file drives
// rd_data, expected beats are queued per dump and checked by a negedge monitor.
module tb_regfile_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [32];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  regfile_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: abstract model tracks only "dump in progress", the pending done
  // pulse and a stalled beat; beat contents come from the scoreboard queue.
  logic          busy_m = 1'b0;
  logic          done_m = 1'b0;
  logic          stall_m = 1'b0;
  logic [AW-1:0] stall_a;
  logic [DW-1:0] stall_d;
  logic          bn, dn, sn;
  beat_t         e_mon;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy_m  = 1'b0;
      done_m  = 1'b0;
      stall_m = 1'b0;
    end else begin
      check("busy", busy, busy_m);
      check("done", done, done_m);
      if (!busy_m) check("valid_while_idle", out_valid, 0);
      if (stall_m) begin
        check("stall_valid", out_valid, 1);
        check("stall_addr", out_addr, stall_a);
        check("stall_data", out_data, stall_d);
      end
      bn = busy_m;
      dn = 1'b0;
      sn = 1'b0;
      if (!busy_m) begin
        if (start) bn = 1'b1;
      end else if (abort) begin
        bn = 1'b0;
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("beat_addr", out_addr, e_mon.a);
          check("beat_data", out_data, e_mon.d);
          check("beat_last", out_last, e_mon.l);
          if (e_mon.l) begin
            bn = 1'b0;
            dn = 1'b1;
          end
        end
      end else if (out_valid) begin
        sn      = 1'b1;
        stall_a = out_addr;
        stall_d = out_data;
      end
      busy_m  = bn;
      done_m  = dn;
      stall_m = sn;
    end
  end

  // Queue the expected beats of a dump, then pulse start for one cycle.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input bit ov, input logic [AW-1:0] oa,
                          input logic [DW-1:0] ovv, output int k);
    int            n;
    beat_t         e;
    logic [AW-1:0] a;
    n = int'(AW'(l - f)) + 1;
    for (int i = 0; i < n; i++) begin
      a   = f + AW'(i);
      e.a = a;
      e.d = (ov && a == oa) ? ovv : regs[a];
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    k          = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    first_addr = AW'($urandom);
    last_addr  = AW'($urandom);
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) check("timeout_wait_idle", 1, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  n;
    bit  stalled;
    bit  hit;
    logic [AW-1:0] f;
    logic [AW-1:0] l;

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;

    // Reset state.
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic 0..3 dump: latency and beat spacing with ready held high.
    hs_cyc.delete();
    run_dump(5'd0, 5'd3, 1'b0, 5'd0, 32'h0, k);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_latency", cyc, k + 2);
    wait_idle(1'b0);
    check("beat_count_0_3", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("beat_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
    @(posedge clk); #1;

    // Wrapping range 30..1, with an ignored second start in the middle.
    run_dump(5'd30, 5'd1, 1'b0, 5'd0, 32'h0, k);
    repeat (2) begin
      @(posedge clk); #1;
    end
    first_addr = 5'd10;
    last_addr  = 5'd12;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    wait_idle(1'b0);
    @(posedge clk); #1;

    // Backpressure: hold out_ready low for 5 cycles on the beat for addr 2.
    run_dump(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, k);
    stalled = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (out_valid && out_addr == 5'd2 && !stalled) begin
        out_ready = 1'b0;
        stalled   = 1'b1;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    check("stall_exercised", stalled, 1);
    wait_idle(1'b0);
    @(posedge clk); #1;

    // Write to regs[5] on the negedge inside its ISSUE cycle must be seen.
    run_dump(5'd5, 5'd6, 1'b1, 5'd5, 32'hDEAD_BEEF, k);
    @(negedge clk);
    regs[5] = 32'hDEAD_BEEF;
    wait_idle(1'b0);
    @(posedge clk); #1;

    // Abort during SEND of addr 7 with ready high: beat dropped, no done.
    run_dump(5'd6, 5'd9, 1'b0, 5'd0, 32'h0, k);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 50) begin
      if (out_valid && out_addr == 5'd7) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid_drop", out_valid, 0);
        check("abort_busy_drop", busy, 0);
        hit = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    check("abort_exercised", hit, 1);
    wait_idle(1'b0);
    @(posedge clk); #1;

    // Start and abort together in IDLE: start wins.
    abort = 1'b1;
    run_dump(5'd0, 5'd1, 1'b0, 5'd0, 32'h0, k);
    abort = 1'b0;
    wait_idle(1'b0);
    @(posedge clk); #1;

    // Async reset mid-dump: outputs clear without a clock edge.
    run_dump(5'd10, 5'd20, 1'b0, 5'd0, 32'h0, k);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_done", done, 0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    wait_idle(1'b0);

    // Randomized ranges, register contents and backpressure.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = AW'($urandom);
      l = AW'($urandom);
      run_dump(f, l, 1'b0, 5'd0, 32'h0, k);
      wait_idle(1'b1);
      @(posedge clk); #1;
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
